dual_slope_seq: RTL
===================

Name: dual_slope_seq

Overview:
- Conversion sequencer for the dual-slope analog front-end. It drives afe_sel, range_sel, afe_reset and ref_sign, and consumes comp, sat_hi, sat_lo and ref_ok.
- Runs discharge → auto-zero → fixed integrate → timed de-integrate. The de-integrate cycle count is the conversion result, published with polarity and an overrange flag.
- Optionally autoranges between conversions. Sits inside digital_top; its results feed the SPI result register.

Parameters:
- RST_CYCLES, 8, cycles afe_reset_o is held high in DISCHARGE.
- AZ_CYCLES, 1000, auto-zero phase length in cycles.
- INT_CYCLES, 1000, fixed integrate (VIN) phase length in cycles.
- DEINT_MAX, 2047, de-integrate timeout in cycles; must be greater than INT_CYCLES.
- CNT_W, 12, counter and result width; 2^CNT_W must exceed DEINT_MAX.
- RANGE_MAX, 5, highest legal range_sel code.
- HI_TH, 1900, result above this steps the range up (autorange).
- LO_TH, 180, result below this steps the range down (autorange).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-low reset
- start_i  in  1  single-cycle pulse; requests one conversion
- cont_i  in  1  level; when high, conversions restart back-to-back
- abort_i  in  1  level; forces DISCHARGE then IDLE
- autorange_en_i  in  1  enables range stepping
- range_man_i  in  3  manual range; loaded when autorange_en_i=0
- comp_i  in  1  comparator, asynchronous; 1 means Vint ≥ 0
- sat_hi_i, sat_lo_i  in  1 each  integrator saturation flags, asynchronous
- ref_ok_i  in  1  reference settled, asynchronous
- afe_sel_o  out  2  00 AZ, 01 VIN, 10 +VREF, 11 −VREF
- range_sel_o  out  3  current range code
- afe_reset_o  out  1  integrator discharge
- ref_sign_o  out  1  0 means +VREF, 1 means −VREF
- busy_o  out  1  high in every state except IDLE
- result_o  out  CNT_W  last de-integrate count
- polarity_o  out  1  sign of last input; 1 means negative
- overrange_o  out  1  last conversion overranged
- result_valid_o  out  1  one-cycle pulse when result_o updates
- state_o  out  3  encoded FSM state, for debug

Behaviour:
- Synchronisers: comp_i, sat_hi_i, sat_lo_i and ref_ok_i each pass through a 2-flop synchroniser (comp_s, sat_s, ref_ok_s). All decisions use the synchronised values.
- Reset (rst_i=0 at a clk_i edge):
  - state=IDLE.
  - afe_sel_o=00, afe_reset_o=1, ref_sign_o=0, range_sel_o=RANGE_MAX.
  - result_o=0, polarity_o=0, overrange_o=0, result_valid_o=0, busy_o=0.
  - Synchroniser flops clear to 0.
- Reset mid-conversion discards the conversion; no result_valid_o is issued.
- FSM encoding: IDLE=0, WAIT_REF=1, DISCHARGE=2, AUTOZERO=3, INTEGRATE=4, DEINT=5, RESULT=6.
- IDLE:
  - afe_reset_o=1, afe_sel_o=00.
  - start_i or cont_i → WAIT_REF. If autorange_en_i=0, range_sel_o ← range_man_i on this transition.
- WAIT_REF: wait for ref_ok_s=1 → DISCHARGE. No timeout.
- DISCHARGE: afe_reset_o=1 for RST_CYCLES cycles → AUTOZERO.
- AUTOZERO: afe_reset_o=0, afe_sel_o=00 for AZ_CYCLES cycles → INTEGRATE.
- INTEGRATE:
  - afe_sel_o=01 for INT_CYCLES cycles.
  - On the last cycle, latch pol=~comp_s.
  - Set ref_sign_o=comp_s and afe_sel_o = comp_s ? 11 : 10, so the reference opposes the integrator charge.
  - sat_s high at any cycle → overrange: set result=all ones and ovr=1, go to RESULT.
- DEINT:
  - Counter starts at 0 and increments every cycle.
  - Exit when comp_s ≠ the value latched at the end of INTEGRATE: count = cycles spent in DEINT. Synchroniser latency is included and not compensated.
  - count reaches DEINT_MAX → ovr=1, result=DEINT_MAX.
- RESULT (one cycle):
  - Register result_o, polarity_o=pol, overrange_o=ovr; pulse result_valid_o=1.
  - afe_sel_o=00, afe_reset_o=1.
  - Autorange (only when autorange_en_i=1):
    - ovr or result>HI_TH → range+1, saturating at RANGE_MAX.
    - Otherwise result<LO_TH → range−1, saturating at 0.
    - The new range applies from the next conversion.
  - Next state: cont_i=1 → WAIT_REF; else IDLE.
- abort_i=1 in any non-IDLE state:
  - Next state DISCHARGE, with the abort latched; after DISCHARGE completes → IDLE.
  - No result_valid_o; result_o is unchanged.
  - abort_i has priority over every other transition.
- start_i while busy_o=1 is ignored; it is not queued.
- Phase counters are CNT_W wide and clear on every state entry. There is no wrap: every exit occurs at or before DEINT_MAX.
- range_sel_o changes only in RESULT or on the IDLE→WAIT_REF transition, never during a conversion.

Test Plan (bench overrides: RST_CYCLES=2, AZ_CYCLES=4, INT_CYCLES=16, DEINT_MAX=40, HI_TH=30, LO_TH=4, RANGE_MAX=5):
- Basic conversion: autorange off, range_man_i=2, ref_ok held high, start_i pulse, comp_i=1 through INTEGRATE, comp_i→0 at 10 DEINT cycles.
  - Required: afe_sel_o sequence 00→01→11; ref_sign_o=1.
  - Required: result_o = 10 + sync latency (12); polarity_o=0; overrange_o=0; single result_valid_o; range_sel_o=2.
- Timeout: comp_i never flips in DEINT → result_o=40, overrange_o=1. With autorange on from range 3, range_sel_o=4 afterwards.
- Saturation: sat_hi_i pulses for 3 cycles during INTEGRATE → RESULT without entering DEINT; result_o=all ones; overrange_o=1.
- Abort: abort_i asserted mid-AUTOZERO → afe_reset_o high for 2 cycles, then IDLE; no result_valid_o; result_o keeps its prior value.
- Continuous mode with reference wait: cont_i=1, ref_ok_i low for 20 cycles → stays in WAIT_REF; results appear back-to-back. Result 2 (<LO_TH) steps range down each conversion until it saturates at 0.
- Reset in DEINT: rst_i=0 for 1 cycle → all outputs at reset values; range_sel_o=5; no result_valid_o.

Source files
------------

// File: rtl/dual_slope_seq.sv
// -----------------------------------------------------------------------------
// dual_slope_seq
//   Conversion sequencer for the dual-slope analog front-end. A conversion
//   runs WAIT_REF -> DISCHARGE -> AUTOZERO -> INTEGRATE -> DEINT -> RESULT.
//   The de-integrate cycle count is the result, published with its polarity
//   and an overrange flag. Between conversions the range may step up or down.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-low reset
//   start_i             one-cycle conversion request (ignored while busy)
//   cont_i              back-to-back conversions while high
//   abort_i             level; discharge the integrator and return to IDLE
//   autorange_en_i      enable range stepping after each result
//   range_man_i         manual range, loaded when autorange_en_i=0
//   comp_i              comparator (async), 1 means Vint >= 0
//   sat_hi_i, sat_lo_i  integrator saturation flags (async)
//   ref_ok_i            reference settled (async)
//   afe_sel_o           00 AZ, 01 VIN, 10 +VREF, 11 -VREF
//   range_sel_o         current range code
//   afe_reset_o         integrator discharge switch
//   ref_sign_o          0 +VREF, 1 -VREF
//   busy_o              high outside IDLE
//   result_o            last de-integrate count
//   polarity_o          1 means the last input was negative
//   overrange_o         last conversion overranged
//   result_valid_o      one-cycle pulse when result_o updates
//   state_o             encoded FSM state
// -----------------------------------------------------------------------------
module dual_slope_seq #(
    parameter int RST_CYCLES = 8,
    parameter int AZ_CYCLES  = 1000,
    parameter int INT_CYCLES = 1000,
    parameter int DEINT_MAX  = 2047,
    parameter int CNT_W      = 12,
    parameter int RANGE_MAX  = 5,
    parameter int HI_TH      = 1900,
    parameter int LO_TH      = 180
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic             abort_i,
    input  logic             autorange_en_i,
    input  logic [2:0]       range_man_i,
    input  logic             comp_i,
    input  logic             sat_hi_i,
    input  logic             sat_lo_i,
    input  logic             ref_ok_i,
    output logic [1:0]       afe_sel_o,
    output logic [2:0]       range_sel_o,
    output logic             afe_reset_o,
    output logic             ref_sign_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] result_o,
    output logic             polarity_o,
    output logic             overrange_o,
    output logic             result_valid_o,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_REF  = 3'd1,
        DISCHARGE = 3'd2,
        AUTOZERO  = 3'd3,
        INTEGRATE = 3'd4,
        DEINT     = 3'd5,
        RESULT    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] AZ_LAST  = CNT_W'(AZ_CYCLES - 1);
    localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(INT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DMAX     = CNT_W'(DEINT_MAX);
    localparam logic [CNT_W-1:0] HI       = CNT_W'(HI_TH);
    localparam logic [CNT_W-1:0] LO       = CNT_W'(LO_TH);
    localparam logic [2:0]       RMAX     = 3'(RANGE_MAX);

    // ---------------- synchronisers ----------------
    logic [1:0] comp_sync, sat_hi_sync, sat_lo_sync, ref_sync;
    logic       comp_s, sat_s, ref_ok_s;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            comp_sync   <= 2'b00;
            sat_hi_sync <= 2'b00;
            sat_lo_sync <= 2'b00;
            ref_sync    <= 2'b00;
        end else begin
            comp_sync   <= {comp_sync[0], comp_i};
            sat_hi_sync <= {sat_hi_sync[0], sat_hi_i};
            sat_lo_sync <= {sat_lo_sync[0], sat_lo_i};
            ref_sync    <= {ref_sync[0], ref_ok_i};
        end
    end

    assign comp_s   = comp_sync[1];
    assign sat_s    = sat_hi_sync[1] | sat_lo_sync[1];
    assign ref_ok_s = ref_sync[1];

    // ---------------- state ----------------
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cref;       // comp_s at the end of INTEGRATE
    logic             pol;
    logic             abort_lat;  // DISCHARGE was entered through an abort

    // End-of-measurement detection: saturation during INTEGRATE, or the
    // comparator crossing / timeout during DEINT.
    logic             fin;
    logic [CNT_W-1:0] fin_res;
    logic             fin_ovr;
    logic             fin_pol;
    logic             abort_go;
    logic [2:0]       rng_nxt;
    logic [2:0]       man_clamped;

    always_comb begin
        fin     = 1'b0;
        fin_res = '0;
        fin_ovr = 1'b0;
        fin_pol = pol;
        case (state)
            INTEGRATE: begin
                if (sat_s) begin
                    fin     = 1'b1;
                    fin_res = '1;
                    fin_ovr = 1'b1;
                    // Polarity was never latched for this conversion; take
                    // the current comparator so the published sign is fresh.
                    fin_pol = ~comp_s;
                end
            end
            DEINT: begin
                if (cnt == DMAX) begin
                    fin     = 1'b1;
                    fin_res = DMAX;
                    fin_ovr = 1'b1;
                end else if (comp_s != cref) begin
                    fin     = 1'b1;
                    fin_res = cnt;
                end
            end
            default: ;
        endcase
    end

    // An abort already being serviced is not restarted, so a held abort_i
    // still lets DISCHARGE run to completion and reach IDLE.
    assign abort_go = abort_i && (state != IDLE) &&
                      !(state == DISCHARGE && abort_lat);

    always_comb begin
        rng_nxt = range_sel_o;
        if (fin_ovr || fin_res > HI) begin
            if (range_sel_o < RMAX) rng_nxt = range_sel_o + 3'd1;
        end else if (fin_res < LO) begin
            if (range_sel_o != 3'd0) rng_nxt = range_sel_o - 3'd1;
        end
    end

    // Out-of-range manual codes are pinned to the highest legal range.
    assign man_clamped = (range_man_i > RMAX) ? RMAX : range_man_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state          <= IDLE;
            cnt            <= '0;
            cref           <= 1'b0;
            pol            <= 1'b0;
            abort_lat      <= 1'b0;
            afe_sel_o      <= 2'b00;
            afe_reset_o    <= 1'b1;
            ref_sign_o     <= 1'b0;
            range_sel_o    <= RMAX;
            result_o       <= '0;
            polarity_o     <= 1'b0;
            overrange_o    <= 1'b0;
            result_valid_o <= 1'b0;
        end else begin
            result_valid_o <= 1'b0;
            if (abort_go) begin
                state       <= DISCHARGE;
                abort_lat   <= 1'b1;
                cnt         <= '0;
                afe_reset_o <= 1'b1;
                afe_sel_o   <= 2'b00;
            end else begin
                case (state)
                    IDLE: begin
                        afe_reset_o <= 1'b1;
                        afe_sel_o   <= 2'b00;
                        cnt         <= '0;
                        if (start_i || cont_i) begin
                            state <= WAIT_REF;
                            if (!autorange_en_i) range_sel_o <= man_clamped;
                        end
                    end
                    WAIT_REF: begin
                        cnt <= '0;
                        if (ref_ok_s) state <= DISCHARGE;
                    end
                    DISCHARGE: begin
                        afe_reset_o <= 1'b1;
                        afe_sel_o   <= 2'b00;
                        if (cnt == RST_LAST) begin
                            cnt <= '0;
                            if (abort_lat) begin
                                state     <= IDLE;
                                abort_lat <= 1'b0;
                            end else begin
                                state       <= AUTOZERO;
                                afe_reset_o <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    AUTOZERO: begin
                        if (cnt == AZ_LAST) begin
                            cnt       <= '0;
                            state     <= INTEGRATE;
                            afe_sel_o <= 2'b01;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    INTEGRATE: begin
                        if (cnt == INT_LAST) begin
                            // Reference polarity opposes the integrated charge.
                            cnt        <= '0;
                            state      <= DEINT;
                            cref       <= comp_s;
                            pol        <= ~comp_s;
                            ref_sign_o <= comp_s;
                            afe_sel_o  <= comp_s ? 2'b11 : 2'b10;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DEINT: begin
                        // Count includes synchroniser latency; never passes DMAX
                        // because reaching it ends the phase.
                        cnt <= cnt + 1'b1;
                    end
                    RESULT: begin
                        cnt   <= '0;
                        state <= cont_i ? WAIT_REF : IDLE;
                    end
                    default: state <= IDLE;
                endcase

                // Publishing overrides the per-state updates above.
                if (fin) begin
                    state          <= RESULT;
                    cnt            <= '0;
                    result_o       <= fin_res;
                    overrange_o    <= fin_ovr;
                    polarity_o     <= fin_pol;
                    result_valid_o <= 1'b1;
                    afe_sel_o      <= 2'b00;
                    afe_reset_o    <= 1'b1;
                    if (autorange_en_i) range_sel_o <= rng_nxt;
                end
            end
        end
    end

    assign busy_o  = (state != IDLE);
    assign state_o = state;

endmodule
